ddr3_port_arbiter: RTL and testbench

- Shares one DDR3 Avalon-MM controller port (512-bit data, 29-bit word address, 3-bit burstcount) between two requesters, r0 and r1.
- Round-robin arbitration. A write burst holds the grant until its last beat.
- Each read command is tagged with its requester, so read-response beats are routed back to the issuer in order.
- Sits between traffic generators/checkers and the DDR3 controller port.

---
 rtl/ddr3_arb_pkg.sv | 22 ++
 rtl/ddr3_rd_tag_fifo.sv | 44 ++++
 rtl/ddr3_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
// rtl/ddr3_arb_pkg.sv - shared widths, FSM state and read-tag types for the DDR3 port arbiter
package ddr3_arb_pkg;
    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 29;
    localparam int BE_W    = 64;
    localparam int BURST_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } state_t;

    typedef struct packed {
        logic               id;
        logic [BURST_W-1:0] len;
    } tag_t;

    // A burstcount of zero is handled as a single beat.
    function automatic logic [BURST_W-1:0] eff_len(input logic [BURST_W-1:0] b);
        return (b == '0) ? BURST_W'(1) : b;
    endfunction
endpackage

// File: rtl/ddr3_rd_tag_fifo.sv
// rtl/ddr3_rd_tag_fifo.sv - in-order FIFO of outstanding read tags {requester id, burst length}
module ddr3_rd_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int TAG_DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  tag_t i_push_tag,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output tag_t o_head
);
    localparam int PW = $clog2(TAG_DEPTH);

    tag_t        r_mem [TAG_DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= i_push_tag;
    end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// rtl/ddr3_port_arbiter.sv - round-robin two-requester arbiter for one DDR3 Avalon-MM port
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int DATA_W    = ddr3_arb_pkg::DATA_W,
    parameter int ADDR_W    = ddr3_arb_pkg::ADDR_W,
    parameter int BE_W      = ddr3_arb_pkg::BE_W,
    parameter int BURST_W   = ddr3_arb_pkg::BURST_W,
    parameter int TAG_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  r0_address,
    input  logic [BURST_W-1:0] r0_burstcount,
    input  logic [DATA_W-1:0]  r0_writedata,
    input  logic [BE_W-1:0]    r0_byteenable,
    input  logic               r0_write,
    input  logic               r0_read,
    output logic               r0_waitrequest,
    output logic [DATA_W-1:0]  r0_readdata,
    output logic               r0_readdatavalid,
    input  logic [ADDR_W-1:0]  r1_address,
    input  logic [BURST_W-1:0] r1_burstcount,
    input  logic [DATA_W-1:0]  r1_writedata,
    input  logic [BE_W-1:0]    r1_byteenable,
    input  logic               r1_write,
    input  logic               r1_read,
    output logic               r1_waitrequest,
    output logic [DATA_W-1:0]  r1_readdata,
    output logic               r1_readdatavalid,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BURST_W-1:0] m_burstcount,
    output logic [DATA_W-1:0]  m_writedata,
    output logic [BE_W-1:0]    m_byteenable,
    output logic               m_write,
    output logic               m_read,
    input  logic               m_waitrequest,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_readdatavalid,
    output logic               err_orphan
);
    state_t             r_state;
    state_t             w_state_next;
    logic               r_last;
    logic               r_owner;
    logic [BURST_W-1:0] r_beats_left;
    logic [BURST_W-1:0] r_rsp_cnt;
    logic               r_err_orphan;
    logic               w_full;
    logic               w_empty;
    tag_t               w_head;
    tag_t               w_push_tag;
    logic [1:0]         w_rd;
    logic [1:0]         w_wr;
    logic [1:0]         w_elig;
    logic               w_win;
    logic               w_any;
    logic               w_acc;
    logic               w_beat;
    logic               w_pop;
    logic [BURST_W-1:0] w_win_len;

    // Read wins over write from the same requester only while a tag slot is free.
    always_comb begin
        w_rd   = {r1_read, r0_read} & {2{~w_full}};
        w_wr   = {r1_write, r0_write} & ~w_rd;
        w_elig = w_rd | w_wr;
        if (r_state == WBURST) begin
            w_win = r_owner;
            w_any = 1'b1;
        end else if (&w_elig) begin
            w_win = ~r_last;
            w_any = 1'b1;
        end else begin
            w_win = w_elig[1];
            w_any = |w_elig;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_acc && m_write && w_win_len != BURST_W'(1)) w_state_next = WBURST;
            WBURST:  if (w_acc && r_beats_left == BURST_W'(1))          w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        m_address    = w_win ? r1_address    : r0_address;
        m_burstcount = w_win ? r1_burstcount : r0_burstcount;
        m_writedata  = w_win ? r1_writedata  : r0_writedata;
        m_byteenable = w_win ? r1_byteenable : r0_byteenable;
        m_write      = 1'b0;
        m_read       = 1'b0;
        if (rst) begin
            if (r_state == WBURST) begin
                m_write = w_win ? r1_write : r0_write;
            end else if (w_any) begin
                m_write = w_wr[w_win];
                m_read  = w_rd[w_win];
            end
        end
        r0_waitrequest = (rst && w_any && !w_win) ? m_waitrequest : 1'b1;
        r1_waitrequest = (rst && w_any &&  w_win) ? m_waitrequest : 1'b1;
    end

    assign w_acc      = (m_read || m_write) && !m_waitrequest;
    assign w_win_len  = eff_len(m_burstcount);
    assign w_push_tag = '{id: w_win, len: w_win_len};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_beats_left <= '0;
        end else if (w_acc) begin
            if (r_state == IDLE) begin
                r_last       <= w_win;
                r_owner      <= w_win;
                r_beats_left <= w_win_len - 1'b1;
            end else begin
                r_beats_left <= r_beats_left - 1'b1;
            end
        end
    end

    assign w_beat           = rst && m_readdatavalid;
    assign w_pop            = w_beat && !w_empty && (r_rsp_cnt == w_head.len - 1'b1);
    assign r0_readdatavalid = w_beat && !w_empty && !w_head.id;
    assign r1_readdatavalid = w_beat && !w_empty &&  w_head.id;
    assign r0_readdata      = m_readdata;
    assign r1_readdata      = m_readdata;
    assign err_orphan       = r_err_orphan;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_cnt    <= '0;
            r_err_orphan <= 1'b0;
        end else if (w_beat) begin
            if (w_empty)    r_err_orphan <= 1'b1;
            else if (w_pop) r_rsp_cnt    <= '0;
            else            r_rsp_cnt    <= r_rsp_cnt + 1'b1;
        end
    end

    ddr3_rd_tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_acc && m_read),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// tb/tb_ddr3_port_arbiter.sv - self-checking bench for ddr3_port_arbiter
module tb_ddr3_port_arbiter;
    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 29;
    localparam int BE_W    = 64;
    localparam int BURST_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0]  r0_address, r1_address, m_address;
    logic [BURST_W-1:0] r0_burstcount, r1_burstcount, m_burstcount;
    logic [DATA_W-1:0]  r0_writedata, r1_writedata, m_writedata;
    logic [BE_W-1:0]    r0_byteenable, r1_byteenable, m_byteenable;
    logic               r0_write, r0_read, r1_write, r1_read;
    logic               r0_waitrequest, r1_waitrequest;
    logic [DATA_W-1:0]  r0_readdata, r1_readdata, m_readdata;
    logic               r0_readdatavalid, r1_readdatavalid;
    logic               m_write, m_read, m_waitrequest, m_readdatavalid;
    logic               err_orphan;

    ddr3_port_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_address(r0_address), .r0_burstcount(r0_burstcount), .r0_writedata(r0_writedata),
        .r0_byteenable(r0_byteenable), .r0_write(r0_write), .r0_read(r0_read),
        .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_burstcount(r1_burstcount), .r1_writedata(r1_writedata),
        .r1_byteenable(r1_byteenable), .r1_write(r1_write), .r1_read(r1_read),
        .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_write(m_write), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .err_orphan(err_orphan)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic               r0w, r0r, r1w, r1r;
        logic               emw, emr, ca;
        logic [ADDR_W-1:0]  eaddr;
        logic [BURST_W-1:0] ebc;
    } vec_t;
    vec_t vecs [8];

    typedef struct {
        int                grant;
        logic              mw, mr;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    int                exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    cmd_t              cmd_q [$];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_address = '0; r0_burstcount = 3'd1; r0_writedata = '0; r0_byteenable = '1;
        r1_address = '0; r1_burstcount = 3'd1; r1_writedata = '0; r1_byteenable = '1;
        r0_write = 0; r0_read = 0; r1_write = 0; r1_read = 0;
        m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic int grant_of();
        if (!r0_waitrequest) return 0;
        if (!r1_waitrequest) return 1;
        return 2;
    endfunction

    initial begin
        int nacc;
        int bad_r1;
        int e;
        cmd_t c;

        // Reset held with active requests and a stray read beat.
        idle_inputs();
        r0_write = 1; r1_read = 1; m_readdatavalid = 1;
        #12;
        chk("rst_m_write", m_write, 0);
        chk("rst_m_read", m_read, 0);
        chk("rst_r0_wait", r0_waitrequest, 1);
        chk("rst_r1_wait", r1_waitrequest, 1);
        chk("rst_rdv", {r1_readdatavalid, r0_readdatavalid}, 0);
        chk("rst_err_orphan", err_orphan, 0);
        idle_inputs();
        do_reset();

        // Combinational arbitration table with the controller stalled.
        vecs[0] = '{0,0,0,0, 0,0,0, 29'h000, 3'd0};
        vecs[1] = '{1,0,0,0, 1,0,1, 29'h111, 3'd2};
        vecs[2] = '{0,0,1,0, 1,0,1, 29'h222, 3'd3};
        vecs[3] = '{0,0,0,1, 0,1,1, 29'h222, 3'd3};
        vecs[4] = '{1,0,1,0, 1,0,1, 29'h111, 3'd2};
        vecs[5] = '{1,1,0,0, 0,1,1, 29'h111, 3'd2};
        vecs[6] = '{0,1,1,0, 0,1,1, 29'h111, 3'd2};
        vecs[7] = '{0,0,1,1, 0,1,1, 29'h222, 3'd3};
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            m_waitrequest = 1;
            r0_address = 29'h111; r0_burstcount = 3'd2;
            r1_address = 29'h222; r1_burstcount = 3'd3;
            r0_write = vecs[i].r0w; r0_read = vecs[i].r0r;
            r1_write = vecs[i].r1w; r1_read = vecs[i].r1r;
            @(negedge clk);
            chk($sformatf("vec%0d_m_write", i), m_write, vecs[i].emw);
            chk($sformatf("vec%0d_m_read", i), m_read, vecs[i].emr);
            chk($sformatf("vec%0d_waits", i), {r1_waitrequest, r0_waitrequest}, 2'b11);
            if (vecs[i].ca) begin
                chk($sformatf("vec%0d_addr", i), m_address, vecs[i].eaddr);
                chk($sformatf("vec%0d_bc", i), m_burstcount, vecs[i].ebc);
            end
            step();
        end

        // Single requester, controller stalling every other cycle.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 100; i++) addr_q.push_back(ADDR_W'(i));
        r0_write = 1;
        nacc = 0;
        bad_r1 = 0;
        for (int cyc = 0; cyc < 400 && nacc < 100; cyc++) begin
            r0_address = ADDR_W'(nacc);
            r0_writedata = DATA_W'(nacc);
            m_waitrequest = (cyc % 2 == 0);
            @(negedge clk);
            if (r1_waitrequest !== 1'b1) bad_r1++;
            if (m_write && !m_waitrequest) begin
                chk("single_addr", m_address, addr_q[0]);
                chk("single_data", m_writedata, DATA_W'(addr_q[0]));
                void'(addr_q.pop_front());
                nacc++;
            end
            step();
        end
        chk("single_accepts", nacc, 100);
        chk("single_r1_wait_drops", bad_r1, 0);

        // Contention between two continuous single-beat writers.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(i % 2);
        r0_write = 1; r0_address = 29'h0A0;
        r1_write = 1; r1_address = 29'h0B0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("contend_grant%0d", i), grant_of(), e);
            chk($sformatf("contend_addr%0d", i), m_address, (e == 1) ? 29'h0B0 : 29'h0A0);
            step();
        end

        // Write burst holds the grant against a pending read.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 4; i++) cmd_q.push_back('{0, 1'b1, 1'b0, 29'h010});
        cmd_q.push_back('{1, 1'b0, 1'b1, 29'h099});
        r0_write = 1; r0_burstcount = 3'd4; r0_address = 29'h010;
        r1_read = 1; r1_address = 29'h099;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            c = cmd_q.pop_front();
            chk($sformatf("burst%0d_grant", i), grant_of(), c.grant);
            chk($sformatf("burst%0d_m_write", i), m_write, c.mw);
            chk($sformatf("burst%0d_m_read", i), m_read, c.mr);
            chk($sformatf("burst%0d_addr", i), m_address, c.addr);
            step();
        end

        // Read responses routed in command order.
        idle_inputs();
        do_reset();
        r0_read = 1; r0_burstcount = 3'd2; r0_address = 29'h020;
        exp_q.push_back(0); exp_q.push_back(0);
        @(negedge clk);
        chk("rd0_m_read", m_read, 1);
        chk("rd0_addr", m_address, 29'h020);
        step();
        r0_read = 0;
        r1_read = 1; r1_burstcount = 3'd1; r1_address = 29'h040;
        exp_q.push_back(1);
        @(negedge clk);
        chk("rd1_m_read", m_read, 1);
        chk("rd1_addr", m_address, 29'h040);
        step();
        r1_read = 0;
        for (int b = 0; b < 3; b++) begin
            m_readdatavalid = 1;
            m_readdata = DATA_W'(32'hD0 + b);
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 2;
            chk($sformatf("beat%0d_rdv0", b), r0_readdatavalid, e == 0);
            chk($sformatf("beat%0d_rdv1", b), r1_readdatavalid, e == 1);
            chk($sformatf("beat%0d_data", b), (e == 1) ? r1_readdata : r0_readdata, DATA_W'(32'hD0 + b));
            step();
        end
        m_readdatavalid = 0;
        @(negedge clk);
        chk("rd_no_orphan", err_orphan, 0);
        step();

        // Tag FIFO full blocks r0 reads but not r1 writes.
        idle_inputs();
        do_reset();
        r0_read = 1; r0_address = 29'h030;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("full_fill%0d", i), m_read, 1);
            step();
        end
        r1_write = 1; r1_address = 29'h050;
        @(negedge clk);
        chk("full_r0_wait", r0_waitrequest, 1);
        chk("full_m_read", m_read, 0);
        chk("full_m_write", m_write, 1);
        chk("full_r1_wait", r1_waitrequest, 0);
        chk("full_addr", m_address, 29'h050);
        step();
        r1_write = 0;
        m_readdatavalid = 1;
        @(negedge clk);
        chk("full_beat_rdv0", r0_readdatavalid, 1);
        chk("full_beat_r0_wait", r0_waitrequest, 1);
        step();
        m_readdatavalid = 0;
        @(negedge clk);
        chk("full_freed_m_read", m_read, 1);
        chk("full_freed_r0_wait", r0_waitrequest, 0);
        step();

        // Reset in the middle of a write burst, then an orphan beat.
        idle_inputs();
        do_reset();
        r0_write = 1; r0_burstcount = 3'd4; r0_address = 29'h060;
        @(negedge clk);
        chk("rstb_beat1", m_write, 1);
        step();
        @(negedge clk);
        chk("rstb_beat2", m_write, 1);
        rst = 1'b0;
        #1;
        chk("rstb_m_write", m_write, 0);
        chk("rstb_waits", {r1_waitrequest, r0_waitrequest}, 2'b11);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        r0_write = 0;
        r1_write = 1; r1_address = 29'h070; m_waitrequest = 1;
        @(negedge clk);
        chk("rstb_idle_m_write", m_write, 1);
        chk("rstb_idle_addr", m_address, 29'h070);
        step();
        r1_write = 0; m_waitrequest = 0;
        m_readdatavalid = 1;
        @(negedge clk);
        chk("orphan_rdv", {r1_readdatavalid, r0_readdatavalid}, 2'b00);
        chk("orphan_err_before", err_orphan, 0);
        step();
        m_readdatavalid = 0;
        @(negedge clk);
        chk("orphan_err_after", err_orphan, 1);
        step();
        @(negedge clk);
        chk("orphan_err_sticky", err_orphan, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
